// File: rtl/fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_if
// Groups the fetch unit's handshake and bus signals:
//   phase controller : fetch_en, inst_ack   (to fetch unit)
//                      inst_valid, inst, inst_pc, fetch_cnt (from fetch unit)
//   execute redirect : redirect_valid, redirect_pc (to fetch unit)
//   instruction mem  : imem_req, imem_addr  (from fetch unit)
//                      imem_gnt, imem_rvalid, imem_rdata (to fetch unit)
// Modport master is the fetch unit's view; slave is the surrounding system.
// ----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        fetch_en;
    logic        inst_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [15:0] fetch_cnt;

    modport master (
        input  fetch_en,
        input  inst_ack,
        input  redirect_valid,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        output fetch_cnt
    );

    modport slave (
        output fetch_en,
        output inst_ack,
        output redirect_valid,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  fetch_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller. Issues one instruction-memory read at a time
// at the current PC, presents the returned word to the phase controller until
// it is acknowledged, and follows taken branches/jumps from Ex.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fetch_ctrl_if.master: phase-controller handshake, redirect,
//          instruction-memory request/response, fetched instruction and count
//
// Parameter:
//   RESET_PC - PC loaded on reset (word aligned)
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;      // outstanding response belongs to a stale PC
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [15:0] r_fetch_cnt;

    // Redirect target with the byte-offset bits dropped.
    logic [31:0] w_redirect_tgt;
    assign w_redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

    // All outputs come straight from registers; the address is the PC itself,
    // so it stays stable in REQ and follows a redirect one cycle later.
    assign bus.imem_req   = r_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = r_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.fetch_cnt  = r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_inst      <= 32'h0;
            r_inst_pc   <= 32'h0;
            r_fetch_cnt <= 16'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_tgt;
                    end else if (bus.fetch_en) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end

                REQ: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_tgt;
                        if (bus.imem_gnt) begin
                            // The granted read is for the old PC; drop its data.
                            r_kill  <= 1'b1;
                            r_state <= WAIT;
                            r_req   <= 1'b0;
                        end
                    end else if (bus.imem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end
                end

                WAIT: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_tgt;
                        if (bus.imem_rvalid) begin
                            // Response arrives with the redirect: it is stale
                            // either way, and nothing remains outstanding.
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_inst      <= bus.imem_rdata;
                            r_inst_pc   <= r_pc;
                            r_pc        <= r_pc + 32'd4;
                            r_fetch_cnt <= r_fetch_cnt + 16'd1;
                            r_valid     <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= w_redirect_tgt;
                        r_valid <= 1'b0;
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end else if (bus.inst_ack) begin
                        r_valid <= 1'b0;
                        if (bus.fetch_en) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'h0, bus.imem_req},   32'h0);
        chk({tag, "_addr"},  bus.imem_addr,           32'h0);
        chk({tag, "_valid"}, {31'h0, bus.inst_valid}, 32'h0);
        chk({tag, "_inst"},  bus.inst,                32'h0);
        chk({tag, "_ipc"},   bus.inst_pc,             32'h0);
        chk({tag, "_cnt"},   {16'h0, bus.fetch_cnt},  32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst                = 1'b1;
        bus.fetch_en       = 1'b1;   // active inputs during reset must not matter
        bus.inst_ack       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_gnt       = 1'b1;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 32'h1234_5678;

        // Reset
        step();
        step();
        chk_reset_vals("rst");
        rst             = 1'b0;
        bus.inst_ack    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;

        // Basic fetch: IDLE -> REQ one cycle after fetch_en
        step();
        chk("b_req", {31'h0, bus.imem_req}, 32'h1);
        chk("b_addr", bus.imem_addr, 32'h0);
        bus.imem_gnt = 1'b1;
        step();
        chk("b_wait_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0050_0093;
        step();
        bus.imem_rvalid = 1'b0;
        chk("b_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("b_inst", bus.inst, 32'h0050_0093);
        chk("b_ipc", bus.inst_pc, 32'h0);
        chk("b_cnt", {16'h0, bus.fetch_cnt}, 32'h1);
        step();
        chk("b_hold_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("b_hold_inst", bus.inst, 32'h0050_0093);
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        chk("b_ack_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("b_next_req", {31'h0, bus.imem_req}, 32'h1);
        chk("b_next_addr", bus.imem_addr, 32'h4);

        // Grant stall: request held with stable address
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gs_req", {31'h0, bus.imem_req}, 32'h1);
            chk("gs_addr", bus.imem_addr, 32'h4);
        end
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("gs_left", {31'h0, bus.imem_req}, 32'h0);

        // Redirect in WAIT: response discarded, refetch at target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        step();
        bus.redirect_valid = 1'b0;
        chk("rw_wait_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rw_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rw_cnt", {16'h0, bus.fetch_cnt}, 32'h1);
        chk("rw_inst", bus.inst, 32'h0050_0093);
        chk("rw_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rw_addr", bus.imem_addr, 32'h100);

        // Fetch at 0x100, then redirect+ack together in HOLD
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rh_inst", bus.inst, 32'h0000_0013);
        chk("rh_ipc", bus.inst_pc, 32'h100);
        chk("rh_cnt", {16'h0, bus.fetch_cnt}, 32'h2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        bus.inst_ack       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.inst_ack       = 1'b0;
        chk("rh_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rh_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rh_addr", bus.imem_addr, 32'h200);

        // PC wrap: redirect in REQ without gnt, then fetch
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("wr_req", {31'h0, bus.imem_req}, 32'h1);
        chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0033;
        step();
        bus.imem_rvalid = 1'b0;
        chk("wr_ipc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wr_cnt", {16'h0, bus.fetch_cnt}, 32'h3);
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        chk("wr_next_addr", bus.imem_addr, 32'h0);
        chk("wr_next_req", {31'h0, bus.imem_req}, 32'h1);

        // fetch_cnt wrap: preload 0xFFFF, complete one fetch
        force dut.r_fetch_cnt = 16'hFFFF;
        #1;
        release dut.r_fetch_cnt;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0073;
        step();
        bus.imem_rvalid = 1'b0;
        chk("cw_cnt", {16'h0, bus.fetch_cnt}, 32'h0);
        chk("cw_ipc", bus.inst_pc, 32'h0);
        chk("cw_inst", bus.inst, 32'h0000_0073);
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        chk("cw_addr", bus.imem_addr, 32'h4);

        // Reset in WAIT, late response ignored
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("rm_wait_req", {31'h0, bus.imem_req}, 32'h0);
        rst = 1'b1;
        step();
        chk_reset_vals("rm");
        rst          = 1'b0;
        bus.fetch_en = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rm_late_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rm_late_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rm_late_cnt", {16'h0, bus.fetch_cnt}, 32'h0);
        bus.fetch_en = 1'b1;
        step();
        chk("rm_restart_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rm_restart_addr", bus.imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC loaded on reset. Bits [1:0] SHALL be 0.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port fetch_en, input, 1 bit: the phase controller is in its Fe phase and permits a new fetch.
REQ-005 Port inst_ack, input, 1 bit: the phase controller consumed the presented instruction (it leaves Fe).
REQ-006 Port redirect_valid, input, 1 bit: a taken branch or jump from Ex.
REQ-007 Port redirect_pc, input, 32 bits: the branch/jump target.
REQ-008 Port imem_req, output, 1 bit: instruction memory request.
REQ-009 Port imem_addr, output, 32 bits: request address, word aligned.
REQ-010 Port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-011 Port imem_rvalid, input, 1 bit: read data valid.
REQ-012 Port imem_rdata, input, 32 bits: read data.
REQ-013 Port inst_valid, output, 1 bit: instruction available; this is the phase controller's ClkMax.
REQ-014 Port inst, output, 32 bits: the fetched instruction.
REQ-015 Port inst_pc, output, 32 bits: the PC of inst.
REQ-016 Port fetch_cnt, output, 16 bits: count of delivered instructions.

Function
REQ-017 The block SHALL be an FSM with states IDLE, REQ, WAIT and HOLD, and at most one imem transaction outstanding.
REQ-018 IDLE: imem_req=0 and inst_valid=0; if fetch_en=1, the next state SHALL be REQ.
REQ-019 REQ behaviour:
- imem_req=1 and imem_addr=pc.
- On imem_gnt=1, the next state SHALL be WAIT.
- Otherwise the block SHALL stay in REQ with imem_addr stable, unless a redirect occurs.
REQ-020 WAIT behaviour:
- imem_req=0.
- On imem_rvalid=1 with kill=0: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, fetch_cnt<=fetch_cnt+1, next state HOLD.
REQ-021 HOLD behaviour:
- inst_valid=1; inst and inst_pc SHALL be held stable until inst_ack.
- On inst_ack, the next state SHALL be REQ if fetch_en=1, else IDLE.
REQ-022 Latency SHALL be 1 cycle from fetch_en to imem_req (IDLE to REQ), and 1 cycle from imem_rvalid to inst_valid.
REQ-023 pc+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC to 0x0000_0000). fetch_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-024 On redirect_valid=1, pc SHALL be loaded with {redirect_pc[31:2],2'b00}; redirect_pc[1:0] SHALL be ignored.
REQ-025 Redirect in IDLE: pc is updated and the state SHALL stay IDLE.
REQ-026 Redirect in REQ:
- Without gnt: imem_addr SHALL take the new pc the next cycle and the state SHALL stay REQ.
- With gnt in the same cycle: kill SHALL be set and the next state SHALL be WAIT.
REQ-027 Redirect in WAIT: kill SHALL be set and the next state SHALL stay WAIT.
REQ-028 Kill handling:
- A response arriving with kill=1 SHALL be discarded: no inst update, no fetch_cnt increment, no pc+4.
- kill SHALL clear on that response and the next state SHALL be REQ.
REQ-029 If redirect_valid and imem_rvalid are both 1 in WAIT with kill=0:
- The response SHALL be discarded.
- pc SHALL be set to the redirect target.
- The next state SHALL be REQ.
REQ-030 Redirect in HOLD: inst_valid SHALL drop the next cycle and the next state SHALL be REQ, regardless of inst_ack.
REQ-031 Priority SHALL be rst > redirect_valid > imem_rvalid/inst_ack.
REQ-032 inst_ack while not in HOLD SHALL be ignored.
REQ-033 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-034 inst_valid SHALL be a registered output with no combinational path from any input.

Reset
REQ-035 On rst=1 at a clock edge, the following values SHALL be loaded:
- state=IDLE, pc=RESET_PC, kill=0.
- imem_req=0, imem_addr=RESET_PC.
- inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0.
REQ-036 Reset asserted mid-transaction (REQ or WAIT) SHALL abandon that transaction.
REQ-037 An imem_rvalid for an abandoned transaction arriving after reset SHALL be ignored, because the block is in IDLE.
REQ-038 Outputs SHALL hold their reset values while rst=1 irrespective of the other inputs.

Verification
REQ-039 Basic fetch:
- Stimulus: reset; fetch_en=1; gnt in cycle 2; rvalid with rdata=0x00500093 in cycle 4.
- Response: imem_addr=0x0 in REQ; inst_valid=1 from cycle 5 with inst=0x00500093, inst_pc=0x0; fetch_cnt=1.
- Then inst_ack, and the next imem_addr=0x4.
REQ-040 Grant stall:
- Stimulus: imem_gnt low for 5 cycles.
- Response: imem_req and imem_addr=0x4 stable throughout; the state leaves REQ only on the gnt cycle.
REQ-041 Redirect in WAIT:
- Stimulus: redirect_pc=0x100 in WAIT, then rvalid with rdata=0xDEADBEEF.
- Response: the response is discarded (inst_valid stays 0, fetch_cnt unchanged); the next imem_addr=0x100.
REQ-042 Simultaneous redirect and inst_ack in HOLD:
- Stimulus: redirect_pc=0x203 with inst_ack in HOLD.
- Response: inst_valid=0 the next cycle; imem_addr=0x200 (low bits ignored).
REQ-043 Wrap:
- Stimulus: redirect to 0xFFFF_FFFC, then complete the fetch.
- Response: inst_pc=0xFFFF_FFFC; the next imem_addr=0x0.
- Preload fetch_cnt=0xFFFF via repeated fetches (or force) and check it rolls to 0.
REQ-044 Reset mid-operation:
- Stimulus: rst=1 in WAIT; release; rvalid arrives late.
- Response: all outputs take their reset values; inst_valid stays 0; the next fetch starts at RESET_PC.
